// File: rtl/password_checker_if.sv
// Bus between the keypad/password-generator side and the password checker.
// Handshake: start, key_valid, key_clr and tick are single-cycle strobes sampled on the rising clk edge; there is no back-pressure.
interface password_checker_if #(
    parameter int PW_W = 8
);
    logic            start;
    logic [PW_W-1:0] password;
    logic            tick;
    logic            key_valid;
    logic [3:0]      key_data;
    logic            key_clr;
    logic            armed;
    logic            defused;
    logic            exploded;
    logic            wrong;
    logic [3:0]      tries_left;
    logic [7:0]      time_left;
    logic [1:0]      digits_entered;
    logic [2:0]      state_dbg;

    modport master (
        output start, password, tick, key_valid, key_data, key_clr,
        input  armed, defused, exploded, wrong, tries_left, time_left,
               digits_entered, state_dbg
    );

    modport slave (
        input  start, password, tick, key_valid, key_data, key_clr,
        output armed, defused, exploded, wrong, tries_left, time_left,
               digits_entered, state_dbg
    );
endinterface

// File: rtl/password_checker.sv
// Bomb-game password checker: latches the password on arm, collects hex digits,
// compares them and tracks remaining tries and the countdown.
module password_checker #(
    parameter int PW_W      = 8,
    parameter int MAX_TRIES = 3,
    parameter int TIME_SEC  = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    password_checker_if.slave  bus
);
    localparam int          NDIG     = PW_W / 4;
    localparam logic [1:0]  LAST_DIG = 2'(NDIG - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        CHECK    = 3'd2,
        DEFUSED  = 3'd3,
        EXPLODED = 3'd4
    } state_t;

    state_t          state;
    logic [PW_W-1:0] pw_reg;
    logic [PW_W-1:0] entry;
    logic [1:0]      digits;
    logic [3:0]      tries;
    logic [7:0]      time_left;
    logic            wrong;
    logic            expire;

    // The last tick of the countdown overrides anything else happening this cycle.
    assign expire = bus.tick && (time_left == 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pw_reg    <= '0;
            entry     <= '0;
            digits    <= '0;
            tries     <= '0;
            time_left <= '0;
            wrong     <= 1'b0;
        end else begin
            wrong <= 1'b0;
            case (state)
                IDLE, DEFUSED, EXPLODED: begin
                    if (bus.start) begin
                        pw_reg    <= bus.password;
                        entry     <= '0;
                        digits    <= '0;
                        tries     <= 4'(MAX_TRIES);
                        time_left <= 8'(TIME_SEC);
                        state     <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (expire) begin
                        time_left <= 8'd0;
                        state     <= EXPLODED;
                    end else begin
                        if (bus.tick && time_left != 8'd0) time_left <= time_left - 8'd1;
                        if (bus.key_clr) begin
                            entry  <= '0;
                            digits <= '0;
                        end else if (bus.key_valid) begin
                            entry  <= {entry[PW_W-5:0], bus.key_data};
                            digits <= digits + 2'd1;
                            if (digits == LAST_DIG) state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (expire) begin
                        time_left <= 8'd0;
                        state     <= EXPLODED;
                    end else begin
                        if (bus.tick && time_left != 8'd0) time_left <= time_left - 8'd1;
                        if (entry == pw_reg) begin
                            state <= DEFUSED;
                        end else begin
                            wrong  <= 1'b1;
                            tries  <= tries - 4'd1;
                            entry  <= '0;
                            digits <= '0;
                            state  <= (tries == 4'd1) ? EXPLODED : ENTRY;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.armed          = (state == ENTRY) || (state == CHECK);
    assign bus.defused        = (state == DEFUSED);
    assign bus.exploded       = (state == EXPLODED);
    assign bus.wrong          = wrong;
    assign bus.tries_left     = tries;
    assign bus.time_left      = time_left;
    assign bus.digits_entered = digits;
    assign bus.state_dbg      = state;
endmodule

// File: tb/tb_password_checker.sv
// Directed bench for password_checker (MAX_TRIES=3, TIME_SEC=3): inputs driven and
// outputs sampled on the falling clock edge.
module tb_password_checker;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    password_checker_if #(.PW_W(8)) bus ();

    password_checker #(
        .PW_W      (8),
        .MAX_TRIES (3),
        .TIME_SEC  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic arm(input logic [7:0] pw);
        bus.password = pw;
        bus.start    = 1'b1;
        cyc();
        bus.start    = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_data  = d;
        cyc();
        bus.key_valid = 1'b0;
    endtask

    task automatic tick1();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.password  = 8'h00;
        bus.tick      = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_data  = 4'h0;
        bus.key_clr   = 1'b0;
        repeat (2) cyc();

        // Reset state
        chk("rst_state", 16'(bus.state_dbg), 16'd0);
        chk("rst_armed", 16'(bus.armed), 16'd0);
        chk("rst_defused", 16'(bus.defused), 16'd0);
        chk("rst_exploded", 16'(bus.exploded), 16'd0);
        chk("rst_tries", 16'(bus.tries_left), 16'd0);
        chk("rst_time", 16'(bus.time_left), 16'd0);
        rst_n = 1'b1;
        cyc();
        key(4'h3);
        chk("idle_key_ignored", 16'(bus.digits_entered), 16'd0);

        // 1: correct first attempt
        arm(8'hA5);
        chk("t1_armed", 16'(bus.armed), 16'd1);
        chk("t1_tries", 16'(bus.tries_left), 16'd3);
        chk("t1_time", 16'(bus.time_left), 16'd3);
        key(4'hA);
        chk("t1_digits1", 16'(bus.digits_entered), 16'd1);
        key(4'h5);
        chk("t1_check_state", 16'(bus.state_dbg), 16'd2);
        chk("t1_not_yet_defused", 16'(bus.defused), 16'd0);
        cyc();
        chk("t1_defused", 16'(bus.defused), 16'd1);
        chk("t1_armed_off", 16'(bus.armed), 16'd0);
        chk("t1_no_wrong", 16'(bus.wrong), 16'd0);
        chk("t1_tries_kept", 16'(bus.tries_left), 16'd3);

        // 2: one miss then a hit
        arm(8'h3C);
        key(4'h1);
        key(4'h2);
        cyc();
        chk("t2_wrong", 16'(bus.wrong), 16'd1);
        chk("t2_tries", 16'(bus.tries_left), 16'd2);
        chk("t2_digits_cleared", 16'(bus.digits_entered), 16'd0);
        chk("t2_back_to_entry", 16'(bus.state_dbg), 16'd1);
        key(4'h3);
        chk("t2_wrong_pulse_ends", 16'(bus.wrong), 16'd0);
        key(4'hC);
        cyc();
        chk("t2_defused", 16'(bus.defused), 16'd1);
        chk("t2_tries_frozen", 16'(bus.tries_left), 16'd2);

        // 3: three misses explode
        arm(8'h00);
        for (int i = 0; i < 3; i++) begin
            key(4'hF);
            key(4'hF);
            cyc();
            chk("t3_wrong", 16'(bus.wrong), 16'd1);
            chk("t3_tries", 16'(bus.tries_left), 16'(2 - i));
        end
        chk("t3_exploded", 16'(bus.exploded), 16'd1);
        chk("t3_not_defused", 16'(bus.defused), 16'd0);
        key(4'h0);
        key(4'h0);
        cyc();
        chk("t3_keys_ignored", 16'(bus.exploded), 16'd1);
        chk("t3_no_more_wrong", 16'(bus.wrong), 16'd0);
        chk("t3_tries_held", 16'(bus.tries_left), 16'd0);

        // 4: countdown runs out
        arm(8'h42);
        tick1();
        chk("t4_time2", 16'(bus.time_left), 16'd2);
        tick1();
        chk("t4_time1", 16'(bus.time_left), 16'd1);
        chk("t4_still_armed", 16'(bus.armed), 16'd1);
        tick1();
        chk("t4_time0", 16'(bus.time_left), 16'd0);
        chk("t4_exploded", 16'(bus.exploded), 16'd1);
        tick1();
        chk("t4_no_wrap", 16'(bus.time_left), 16'd0);

        // 5: clear beats a simultaneous digit; start ignored while armed
        arm(8'hA5);
        key(4'h7);
        chk("t5_digits1", 16'(bus.digits_entered), 16'd1);
        arm(8'h11);
        chk("t5_start_ignored", 16'(bus.digits_entered), 16'd1);
        bus.key_clr = 1'b1;
        key(4'h9);
        bus.key_clr = 1'b0;
        chk("t5_cleared", 16'(bus.digits_entered), 16'd0);
        key(4'hA);
        key(4'h5);
        cyc();
        chk("t5_defused", 16'(bus.defused), 16'd1);

        // 6: expiry beats a matching check; async reset mid-entry
        arm(8'hA5);
        tick1();
        tick1();
        key(4'hA);
        key(4'h5);
        chk("t6_in_check", 16'(bus.state_dbg), 16'd2);
        tick1();
        chk("t6_exploded", 16'(bus.exploded), 16'd1);
        chk("t6_not_defused", 16'(bus.defused), 16'd0);
        chk("t6_time0", 16'(bus.time_left), 16'd0);
        arm(8'hA5);
        key(4'hA);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_state", 16'(bus.state_dbg), 16'd0);
        chk("t6_rst_armed", 16'(bus.armed), 16'd0);
        chk("t6_rst_digits", 16'(bus.digits_entered), 16'd0);
        chk("t6_rst_tries", 16'(bus.tries_left), 16'd0);
        chk("t6_rst_time", 16'(bus.time_left), 16'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
